// File: rtl/neopixel_pkg.sv
// rtl/neopixel_pkg.sv - shared modes, colour constants and timing defaults for the neopixel frame driver
package neopixel_pkg;

  typedef enum logic [1:0] {
    MODE_REVEAL  = 2'b00,
    MODE_IDLE    = 2'b01,
    MODE_LOADING = 2'b10,
    MODE_SCORING = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HIGH,
    S_LOW,
    S_LATCH,
    S_DONE
  } state_e;

  localparam logic [2:0] FB_RED   = 3'd7;
  localparam logic [2:0] FB_WHITE = 3'd1;

  localparam logic [7:0]  LVL       = 8'h20;
  localparam logic [23:0] RGB_OFF   = 24'h000000;
  localparam logic [23:0] RGB_RED   = {LVL, 8'h00, 8'h00};
  localparam logic [23:0] RGB_GREEN = {8'h00, LVL, 8'h00};
  localparam logic [23:0] RGB_BLUE  = {8'h00, 8'h00, LVL};
  localparam logic [23:0] RGB_YEL   = {LVL, LVL, 8'h00};
  localparam logic [23:0] RGB_CYAN  = {8'h00, LVL, LVL};
  localparam logic [23:0] RGB_MAG   = {LVL, 8'h00, LVL};
  localparam logic [23:0] RGB_WHITE = {LVL, LVL, LVL};

  localparam int T0H_DEF    = 20;
  localparam int T1H_DEF    = 40;
  localparam int TBIT_DEF   = 63;
  localparam int TLATCH_DEF = 2600;

  function automatic logic [23:0] lut_rgb(input logic [2:0] code);
    case (code)
      3'd0:    return RGB_RED;
      3'd1:    return RGB_GREEN;
      3'd2:    return RGB_BLUE;
      3'd3:    return RGB_YEL;
      3'd4:    return RGB_CYAN;
      3'd5:    return RGB_MAG;
      default: return RGB_OFF;
    endcase
  endfunction

  // WS2812 expects green first on the wire.
  function automatic logic [23:0] rgb_to_grb(input logic [23:0] rgb);
    return {rgb[15:8], rgb[23:16], rgb[7:0]};
  endfunction

endpackage

// File: rtl/neopixel_pixel_encoder.sv
// rtl/neopixel_pixel_encoder.sv - maps game state for one pixel slot to a 24-bit GRB word
module neopixel_pixel_encoder
  import neopixel_pkg::*;
(
  input  logic [1:0]  st,
  input  logic        won,
  input  logic        lost,
  input  logic        upper,
  input  logic [2:0]  guess_code,
  input  logic [2:0]  pattern_code,
  input  logic [2:0]  fb_code,
  input  logic        loaded,
  output logic [23:0] grb
);

  logic [23:0] rgb;

  always_comb begin
    rgb = RGB_OFF;
    case (mode_e'(st))
      MODE_SCORING: begin
        if (!upper)                rgb = lut_rgb(guess_code);
        else if (fb_code == FB_RED)   rgb = RGB_RED;
        else if (fb_code == FB_WHITE) rgb = RGB_WHITE;
      end
      MODE_REVEAL: begin
        if (!upper)    rgb = lut_rgb(pattern_code);
        else if (won)  rgb = RGB_GREEN;
        else if (lost) rgb = RGB_RED;
      end
      default: begin
        if (!upper && loaded) rgb = RGB_WHITE;
      end
    endcase
  end

  assign grb = rgb_to_grb(rgb);

endmodule

// File: rtl/neopixel_frame_driver.sv
// rtl/neopixel_frame_driver.sv - snapshots game state into an 8-pixel frame and shifts it out on a WS2812 line
module neopixel_frame_driver
  import neopixel_pkg::*;
#(
  parameter int T0H    = T0H_DEF,
  parameter int T1H    = T1H_DEF,
  parameter int TBIT   = TBIT_DEF,
  parameter int TLATCH = TLATCH_DEF
) (
  input  logic        clock,
  input  logic        reset_L,
  input  logic        start,
  input  logic [1:0]  st,
  input  logic [11:0] guess,
  input  logic [11:0] pattern,
  input  logic [11:0] feedback,
  input  logic [3:0]  loaded_i,
  input  logic        won,
  input  logic        lost,
  output logic        neopixel_data,
  output logic        busy,
  output logic        done
);

  localparam int TW = $clog2(TBIT);
  localparam int LW = $clog2(TLATCH);
  localparam logic [TW-1:0] TBIT_LAST   = TW'(TBIT - 1);
  localparam logic [TW-1:0] T0H_LAST    = TW'(T0H - 1);
  localparam logic [TW-1:0] T1H_LAST    = TW'(T1H - 1);
  localparam logic [LW-1:0] TLATCH_LAST = LW'(TLATCH - 1);

  state_e            state, state_n;
  logic [7:0][23:0]  frame_q, frame_d;
  logic [TW-1:0]     tcnt;
  logic [4:0]        bit_idx;
  logic [2:0]        pix_idx;
  logic [LW-1:0]     lcnt;
  logic              cur_bit, last_bit, bit_end, accept;

  for (genvar p = 0; p < 8; p++) begin : g_pix
    localparam int   SLOT = p % 4;
    localparam logic UP   = (p >= 4);
    neopixel_pixel_encoder u_enc (
      .st           (st),
      .won          (won),
      .lost         (lost),
      .upper        (UP),
      .guess_code   (guess[3*SLOT +: 3]),
      .pattern_code (pattern[3*SLOT +: 3]),
      .fb_code      (feedback[3*SLOT +: 3]),
      .loaded       (loaded_i[SLOT]),
      .grb          (frame_d[p])
    );
  end

  assign accept   = (state == S_IDLE) && start;
  assign cur_bit  = frame_q[pix_idx][5'd23 - bit_idx];
  assign last_bit = (pix_idx == 3'd7) && (bit_idx == 5'd23);
  assign bit_end  = (state == S_LOW) && (tcnt == TBIT_LAST);

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_HIGH;
      S_HIGH:  if (tcnt == (cur_bit ? T1H_LAST : T0H_LAST)) state_n = S_LOW;
      S_LOW:   if (tcnt == TBIT_LAST) state_n = last_bit ? S_LATCH : S_HIGH;
      S_LATCH: if (lcnt == TLATCH_LAST) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state   <= S_IDLE;
      frame_q <= '0;
      tcnt    <= '0;
      bit_idx <= '0;
      pix_idx <= '0;
      lcnt    <= '0;
    end else begin
      state <= state_n;
      if (accept) frame_q <= frame_d;

      // The bit timer runs through HIGH and LOW so every bit spans exactly TBIT cycles.
      if (state == S_HIGH || state == S_LOW)
        tcnt <= (tcnt == TBIT_LAST) ? '0 : tcnt + 1'b1;
      else
        tcnt <= '0;

      if (bit_end) begin
        bit_idx <= (bit_idx == 5'd23) ? 5'd0 : bit_idx + 5'd1;
        if (bit_idx == 5'd23) pix_idx <= (pix_idx == 3'd7) ? 3'd0 : pix_idx + 3'd1;
      end

      lcnt <= (state == S_LATCH) ? lcnt + 1'b1 : '0;
    end
  end

  // Outputs are registered off the next state so they line up with the state they describe.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      neopixel_data <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      neopixel_data <= (state_n == S_HIGH);
      busy          <= (state_n != S_IDLE);
      done          <= (state_n == S_DONE);
    end
  end

endmodule

// File: tb/tb_neopixel_frame_driver.sv
// tb/tb_neopixel_frame_driver.sv - scoreboard bench decoding the WS2812 line against a frame model
module tb_neopixel_frame_driver;

  logic        clock = 1'b0;
  logic        reset_L = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  st = 2'b01;
  logic [11:0] guess = '0, pattern = '0, feedback = '0;
  logic [3:0]  loaded_i = '0;
  logic        won = 1'b0, lost = 1'b0;
  logic        neopixel_data, busy, done;

  always #5 clock = ~clock;

  neopixel_frame_driver dut (
    .clock         (clock),
    .reset_L       (reset_L),
    .start         (start),
    .st            (st),
    .guess         (guess),
    .pattern       (pattern),
    .feedback      (feedback),
    .loaded_i      (loaded_i),
    .won           (won),
    .lost          (lost),
    .neopixel_data (neopixel_data),
    .busy          (busy),
    .done          (done)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint obs, input longint expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [23:0] lut_grb(input logic [2:0] c);
    case (c)
      3'd0:    return 24'h002000;
      3'd1:    return 24'h200000;
      3'd2:    return 24'h000020;
      3'd3:    return 24'h202000;
      3'd4:    return 24'h200020;
      3'd5:    return 24'h002020;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] model_pix(input int p);
    int s;
    logic [2:0] f;
    s = p % 4;
    f = feedback[3*s +: 3];
    if (st == 2'b11) begin
      if (p < 4) return lut_grb(guess[3*s +: 3]);
      return (f == 3'd7) ? 24'h002000 : (f == 3'd1) ? 24'h202020 : 24'h000000;
    end
    if (st == 2'b00) begin
      if (p < 4) return lut_grb(pattern[3*s +: 3]);
      return won ? 24'h200000 : lost ? 24'h002000 : 24'h000000;
    end
    return (p < 4 && loaded_i[s]) ? 24'h202020 : 24'h000000;
  endfunction

  logic [23:0] exp_q[$];
  int          rise_q[$];

  task automatic push_frame();
    for (int p = 0; p < 8; p++) exp_q.push_back(model_pix(p));
  endtask

  // Line monitor: decodes bits from pulse widths and checks timing.
  logic        prev_d = 1'b0, prev_done = 1'b0;
  logic [23:0] word = '0;
  logic [23:0] want;
  logic        eb;
  int in_frame = 0, first_rise = 0, last_rise = 0, high_start = 0;
  int bpos = 0, mon_bits = 0, done_cnt = 0;

  always @(negedge clock) begin
    if (!reset_L) begin
      prev_d = 1'b0; prev_done = 1'b0; in_frame = 0; bpos = 0; mon_bits = 0;
      exp_q.delete(); rise_q.delete();
    end else begin
      if (neopixel_data && !prev_d) begin
        if (in_frame == 0) begin
          chk("first_rise_expected", rise_q.size() > 0, 1);
          if (rise_q.size() > 0) chk("first_rise_cycle", cyc, rise_q.pop_front());
          in_frame = 1;
          first_rise = cyc;
        end else begin
          chk("rise_spacing", cyc - last_rise, 63);
        end
        last_rise = cyc;
        high_start = cyc;
      end
      if (!neopixel_data && prev_d) begin
        chk("bit_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          want = exp_q[0];
          eb = want[23 - bpos];
          chk("high_width", cyc - high_start, eb ? 40 : 20);
        end
        word = {word[22:0], (cyc - high_start) > 30};
        bpos++;
        mon_bits++;
        if (bpos == 24) begin
          bpos = 0;
          if (exp_q.size() > 0) chk("pixel_grb", word, exp_q.pop_front());
        end
      end
      if (done) begin
        chk("done_width", prev_done, 0);
        chk("done_in_frame", in_frame, 1);
        chk("done_bits", mon_bits, 192);
        chk("done_time", cyc - first_rise, 14696);
        chk("latch_gap", cyc - last_rise - 63, 2600);
        chk("busy_at_done", busy, 1);
        in_frame = 0;
        mon_bits = 0;
        done_cnt++;
      end
      prev_d = neopixel_data;
      prev_done = done;
    end
  end

  task automatic send();
    @(negedge clock);
    start = 1'b1;
    push_frame();
    rise_q.push_back(cyc + 1);
    @(negedge clock);
    start = 1'b0;
    chk("busy_after_accept", busy, 1);
  endtask

  task automatic wait_done(output int dc);
    int n;
    n = 0;
    dc = -1;
    while (n < 16000) begin
      @(negedge clock);
      n++;
      if (done) begin
        dc = cyc;
        break;
      end
    end
    chk("done_seen", dc >= 0, 1);
  endtask

  int dc, d0, n;

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_data", neopixel_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset_L = 1'b1;
    @(negedge clock);

    // Abort a scoring frame at bit 50.
    st = 2'b11; guess = 12'o0123; feedback = 12'o7710;
    send();
    n = 0;
    while (mon_bits < 50 && n < 5000) begin
      @(negedge clock);
      n++;
    end
    chk("reach_bit50", mon_bits >= 50, 1);
    d0 = done_cnt;
    @(posedge clock);
    #2 reset_L = 1'b0;
    #1;
    chk("abort_data", neopixel_data, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    repeat (4) @(negedge clock);
    @(posedge clock);
    #2 reset_L = 1'b1;
    repeat (20) @(negedge clock);
    chk("abort_no_done", done_cnt, d0);
    chk("abort_idle_busy", busy, 0);
    chk("abort_idle_data", neopixel_data, 0);

    // Full scoring frame after the abort.
    send();
    wait_done(dc);
    @(negedge clock);
    chk("post_done_busy", busy, 0);
    chk("post_done_low", done, 0);

    // Reveal, start held: won frame then lost frame, one idle cycle apart.
    st = 2'b00; pattern = 12'o5555; won = 1'b1; lost = 1'b0;
    @(negedge clock);
    start = 1'b1;
    push_frame();
    rise_q.push_back(cyc + 1);
    @(negedge clock);
    chk("b2b_busy", busy, 1);
    won = 1'b0; lost = 1'b1;
    push_frame();
    wait_done(dc);
    rise_q.push_back(dc + 2);
    wait_done(dc);
    start = 1'b0;
    repeat (3) @(negedge clock);
    chk("b2b_idle_busy", busy, 0);
    chk("b2b_starts_consumed", rise_q.size(), 0);

    // Loading frame; inputs change after capture.
    st = 2'b10; loaded_i = 4'b0101; won = 1'b0; lost = 1'b0;
    send();
    loaded_i = 4'b1111; st = 2'b11;
    wait_done(dc);
    repeat (2) @(negedge clock);
    chk("final_pixels_consumed", exp_q.size(), 0);
    chk("frames_done", done_cnt, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
